slave_r_buffer: RTL

SLAVE_R_BUFFER -- requirements
Module: slave_r_buffer

---
 rtl/slave_r_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/slave_r_buffer.sv
// R-channel beat buffer: a BUFF_DEPTH-entry FIFO between an upstream responder and a
// downstream initiator, with a burst-completion pulse and a sticky SLVERR/DECERR flag.
module slave_r_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 10,
  parameter int BUFF_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          test_en_i,

  input  logic                          slave_valid_i,
  input  logic [DATA_WIDTH-1:0]         slave_data_i,
  input  logic [ID_WIDTH-1:0]           slave_id_i,
  input  logic [1:0]                    slave_resp_i,
  input  logic [USER_WIDTH-1:0]         slave_user_i,
  input  logic                          slave_last_i,
  output logic                          slave_ready_o,

  output logic                          master_valid_o,
  output logic [DATA_WIDTH-1:0]         master_data_o,
  output logic [ID_WIDTH-1:0]           master_id_o,
  output logic [1:0]                    master_resp_o,
  output logic [USER_WIDTH-1:0]         master_user_o,
  output logic                          master_last_o,
  input  logic                          master_ready_i,

  output logic [$clog2(BUFF_DEPTH):0]   count_o,
  output logic                          burst_done_o,
  output logic                          err_o,
  input  logic                          err_clr_i
);

  localparam int AW = $clog2(BUFF_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + ID_WIDTH + 2 + USER_WIDTH + 1;

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // Both ready and valid come from the registered count only, so neither side's
  // input can reach the other side's outputs combinationally.

  logic [EW-1:0] mem [BUFF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [EW-1:0] rd_entry;
  logic          burst_done_q;
  logic          err_q;
  logic          unused_test_en;

  assign unused_test_en = test_en_i;

  assign slave_ready_o  = (count != CW'(BUFF_DEPTH));
  assign master_valid_o = (count != '0);
  assign push           = slave_valid_i & slave_ready_o;
  assign pop            = master_valid_o & master_ready_i;

  // Payload is forced to zero whenever the buffer is empty, which also covers reset.
  assign rd_entry = master_valid_o ? mem[rd_ptr] : '0;
  assign {master_data_o, master_id_o, master_resp_o, master_user_o, master_last_o} = rd_entry;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {slave_data_i, slave_id_i, slave_resp_i, slave_user_i, slave_last_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A set from a delivered error response takes priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      burst_done_q <= pop & master_last_o;
      if (pop && master_resp_o[1]) err_q <= 1'b1;
      else if (err_clr_i)          err_q <= 1'b0;
    end
  end

  assign count_o      = count;
  assign burst_done_o = burst_done_q;
  assign err_o        = err_q;

endmodule
